// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared types, defaults and helpers for seq_detect_prog.
//   seq_state_t   : detector FSM states (UNCFG, FILL, ARMED, HIT).
//   SEQ_DEF_*     : default parameter values for the detector.
//   seq_clamp_len : folds a loaded pattern length into the range 1..max_len.
package seq_detect_pkg;

    localparam int SEQ_DEF_MAX_LEN = 8;
    localparam int SEQ_DEF_CNT_W   = 8;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2,
        HIT   = 2'd3
    } seq_state_t;

    // A zero-length pattern would never match anything, so it is treated
    // as a single symbol. Over-long patterns are cut to the history depth.
    function automatic int seq_clamp_len(input int len_in, input int max_len);
        if (len_in <= 0) begin
            return 1;
        end
        if (len_in > max_len) begin
            return max_len;
        end
        return len_in;
    endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// seq_match_cmp: combinational masked compare of the shifted history
// against the loaded pattern. Only the low `len` bits take part; bits at
// positions >= len are ignored.
//   hist_n : next history value (newest symbol in bit 0)
//   pat    : loaded pattern (last expected symbol in bit 0)
//   len    : active pattern length (1..MAX_LEN)
//   eq     : 1 when hist_n[len-1:0] == pat[len-1:0]
module seq_match_cmp #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic [MAX_LEN-1:0] hist_n,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    output logic               eq
);

    logic [MAX_LEN-1:0] bit_ok;

    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_bit
        localparam logic [LEN_W-1:0] IDX = LEN_W'(gi);
        assign bit_ok[gi] = (IDX >= len) || (hist_n[gi] == pat[gi]);
    end

    assign eq = &bit_ok;

endmodule

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable-pattern Moore sequence detector.
// A pattern of 1..MAX_LEN bits is loaded at run time; qualified serial
// symbols are shifted into a history register and compared against it.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   din_valid, din        : serial symbol and its qualifier
//   cfg_load              : strobe capturing cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern, cfg_len  : pattern (first symbol at bit len-1) and length
//   cfg_overlap           : 1 = overlapping matches allowed
//   z                     : match indication, high in the HIT state
//   armed                 : history holds at least len fresh symbols
//   match_count, count_sat: saturating match counter (only when the macro
//                           SEQ_DETECT_PROG_COUNT_EN is defined)
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter  int MAX_LEN = SEQ_DEF_MAX_LEN,
    parameter  int CNT_W   = SEQ_DEF_CNT_W,
    localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               z,
`ifdef SEQ_DETECT_PROG_COUNT_EN
    output logic               armed,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
`else
    output logic               armed
`endif
);

    seq_state_t         state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
`ifdef SEQ_DETECT_PROG_COUNT_EN
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic               cmp_eq;
    logic               match;

    assign hist_n = {hist_q[MAX_LEN-2:0], din};
    // fill never exceeds len, so saturating at len is an equality test.
    assign fill_n = (fill_q == len_q) ? len_q : fill_q + LEN_W'(1);

    seq_match_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .hist_n (hist_n),
        .pat    (pat_q),
        .len    (len_q),
        .eq     (cmp_eq)
    );

    assign match = (fill_n == len_q) && cmp_eq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= UNCFG;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
`ifdef SEQ_DETECT_PROG_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
`ifdef SEQ_DETECT_PROG_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
`ifdef SEQ_DETECT_PROG_COUNT_EN
        cnt_d   = cnt_q;
`endif

        if (cfg_load) begin
            // Loading wins over any symbol presented in the same cycle.
            pat_d   = cfg_pattern;
            len_d   = LEN_W'(seq_clamp_len(int'(cfg_len), MAX_LEN));
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILL;
`ifdef SEQ_DETECT_PROG_COUNT_EN
            cnt_d   = '0;
`endif
        end else if (state_q != UNCFG && din_valid) begin
            hist_d = hist_n;
            if (match) begin
                state_d = HIT;
                // Non-overlap mode demands len fresh symbols for the next hit.
                fill_d  = ovl_q ? fill_n : '0;
`ifdef SEQ_DETECT_PROG_COUNT_EN
                if (!(&cnt_q)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end else begin
                fill_d  = fill_n;
                state_d = (fill_n == len_q) ? ARMED : FILL;
            end
        end else begin
            case (state_q)
                HIT:     state_d = (fill_q == len_q) ? ARMED : FILL;
                default: state_d = state_q;
            endcase
        end
    end

    assign z     = (state_q == HIT);
    assign armed = (state_q == ARMED) || (state_q == HIT);

`ifdef SEQ_DETECT_PROG_COUNT_EN
    assign match_count = cnt_q;
    assign count_sat   = &cnt_q;
`endif

endmodule
